// File: rtl/sa_tile_scheduler.sv
// ============================================================================
// Module   : sa_tile_scheduler
// Brief    : Sequences weight load, activation streaming and result drain
//            for one ARRAY_N x ARRAY_N systolic tile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_tile_scheduler #(
    parameter int ARRAY_N = 8,
    parameter int DIM_W   = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       start,
    input  logic                       abort,
    input  logic [DIM_W-1:0]           cfg_m,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    input  logic                       w_valid,
    output logic                       w_ready,
    output logic [$clog2(ARRAY_N)-1:0] w_row,
    output logic                       sa_w_load,
    input  logic                       a_valid,
    output logic                       a_ready,
    output logic                       sa_en,
    output logic                       a_zero,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_last
);

    localparam int                   LAT        = 2 * ARRAY_N - 1;
    localparam int                   c_ROW_W    = $clog2(ARRAY_N);
    localparam logic [c_ROW_W-1:0]   c_LAST_ROW = c_ROW_W'(ARRAY_N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIM_W-1:0]   r_m;
    logic [DIM_W-1:0]   r_a_cnt;
    logic [DIM_W-1:0]   r_r_cnt;
    logic [c_ROW_W-1:0] r_w_row;
    logic [LAT-1:0]     r_vsr;
    logic               r_cfg_err;
    logic               w_adv;
    logic               w_a_acc;
    logic               w_res_acc;
    logic               w_last_res;
    logic               w_kill;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_adv      = !res_valid || res_ready;
        sa_en      = w_adv && (r_state == S_STREAM || r_state == S_FLUSH);
        w_ready    = (r_state == S_LOAD_W);
        sa_w_load  = w_valid && w_ready;
        w_row      = r_w_row;
        a_ready    = (r_state == S_STREAM) && w_adv && (r_a_cnt < r_m);
        w_a_acc    = a_valid && a_ready;
        // In STREAM with sa_en high a_ready is also high, so a missing row is a bubble.
        a_zero     = sa_en && ((r_state == S_FLUSH) || (r_state == S_STREAM && !a_valid));
        res_valid  = r_vsr[LAT-1];
        w_res_acc  = res_valid && res_ready;
        w_last_res = (r_r_cnt == r_m - DIM_W'(1));
        res_last   = res_valid && w_last_res;
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        cfg_err    = r_cfg_err;
        w_kill     = abort && busy;

        case (r_state)
            S_IDLE:   if (start && cfg_m != '0) w_next = S_LOAD_W;
            S_LOAD_W: if (sa_w_load && r_w_row == c_LAST_ROW) w_next = S_STREAM;
            S_STREAM: if (w_a_acc && r_a_cnt == r_m - DIM_W'(1)) w_next = S_FLUSH;
            S_FLUSH:  if (w_res_acc && w_last_res) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase

        if (w_kill) w_next = S_IDLE;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_m       <= '0;
            r_a_cnt   <= '0;
            r_r_cnt   <= '0;
            r_w_row   <= '0;
            r_vsr     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == S_IDLE) && start && (cfg_m == '0);
            if (w_kill) begin
                r_a_cnt <= '0;
                r_r_cnt <= '0;
                r_w_row <= '0;
                r_vsr   <= '0;
            end else begin
                if (r_state == S_IDLE && start) begin
                    r_m     <= cfg_m;
                    r_a_cnt <= '0;
                    r_r_cnt <= '0;
                end
                if (sa_w_load) begin
                    r_w_row <= (r_w_row == c_LAST_ROW) ? '0 : r_w_row + c_ROW_W'(1);
                end
                if (w_a_acc) r_a_cnt <= r_a_cnt + DIM_W'(1);
                if (w_res_acc) r_r_cnt <= r_r_cnt + DIM_W'(1);
                // Valid tag travels with the array pipeline: 1 = real row, 0 = bubble.
                if (sa_en) r_vsr <= (r_vsr << 1) | LAT'(w_a_acc);
                if (r_state == S_DONE) begin
                    r_a_cnt <= '0;
                    r_r_cnt <= '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sa_tile_scheduler.sv
// ============================================================================
// Module   : tb_sa_tile_scheduler
// Brief    : Directed cycle-table bench for sa_tile_scheduler (ARRAY_N=4, DIM_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_tile_scheduler;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       start, abort;
    logic [3:0] cfg_m;
    logic       busy, done, cfg_err;
    logic       w_valid, w_ready, sa_w_load;
    logic [1:0] w_row;
    logic       a_valid, a_ready, sa_en, a_zero;
    logic       res_valid, res_ready, res_last;

    int n_checks = 0;
    int n_err    = 0;

    always #5 ACLK = ~ACLK;

    sa_tile_scheduler #(.ARRAY_N(4), .DIM_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort), .cfg_m(cfg_m),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .sa_w_load(sa_w_load),
        .a_valid(a_valid), .a_ready(a_ready), .sa_en(sa_en), .a_zero(a_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic inr(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // mode: 0 nominal, 1 backpressure, 2 bubbles, 3 max cfg_m, 4 abort, 5 reset mid-tile, 6 cfg_m=0
    task automatic run(input int mode, input int ncyc);
        logic e_wl, e_ar, e_en, e_az, e_rv, e_rl, e_dn, e_by, e_ce;
        logic [1:0] e_row;
        for (int c = 0; c <= ncyc; c++) begin
            start     = (c == 0) || (mode == 3 && c == 8) || (mode == 5 && c == 10);
            cfg_m     = (mode == 6) ? 4'd0 : (mode == 3) ? ((c == 0) ? 4'd15 : 4'd1) : 4'd3;
            abort     = (mode == 4 && c == 6) || (mode == 5 && c == 10);
            ARESET    = (mode == 5 && c == 10);
            res_ready = !(mode == 1 && inr(c, 12, 14));
            a_valid   = !(mode == 2 && inr(c, 5, 6));
            w_valid   = 1'b1;
            #1;
            e_wl  = (mode != 6) && inr(c, 1, 4);
            e_row = e_wl ? 2'(c - 1) : 2'd0;
            e_ce  = (mode == 6) && (c == 1);
            case (mode)
                0: begin e_ar = inr(c,5,7);  e_en = inr(c,5,14); e_az = inr(c,8,14);
                         e_rv = inr(c,12,14); e_rl = (c == 14); e_dn = (c == 15); e_by = inr(c,1,15); end
                1: begin e_ar = inr(c,5,7);  e_en = inr(c,5,11) || inr(c,15,17);
                         e_az = inr(c,8,11) || inr(c,15,17);
                         e_rv = inr(c,12,17); e_rl = (c == 17); e_dn = (c == 18); e_by = inr(c,1,18); end
                2: begin e_ar = inr(c,5,9);  e_en = inr(c,5,16); e_az = inr(c,5,6) || inr(c,10,16);
                         e_rv = inr(c,14,16); e_rl = (c == 16); e_dn = (c == 17); e_by = inr(c,1,17); end
                3: begin e_ar = inr(c,5,19); e_en = inr(c,5,26); e_az = inr(c,20,26);
                         e_rv = inr(c,12,26); e_rl = (c == 26); e_dn = (c == 27); e_by = inr(c,1,27); end
                4: begin e_ar = inr(c,5,6);  e_en = inr(c,5,6);  e_az = 1'b0;
                         e_rv = 1'b0; e_rl = 1'b0; e_dn = 1'b0; e_by = inr(c,1,6); end
                5: begin e_ar = inr(c,5,7);  e_en = inr(c,5,10); e_az = inr(c,8,10);
                         e_rv = 1'b0; e_rl = 1'b0; e_dn = 1'b0; e_by = inr(c,1,10); end
                default: begin e_ar = 1'b0; e_en = 1'b0; e_az = 1'b0;
                         e_rv = 1'b0; e_rl = 1'b0; e_dn = 1'b0; e_by = 1'b0; end
            endcase
            chk($sformatf("m%0d_busy", mode),      c, 32'(busy),      32'(e_by));
            chk($sformatf("m%0d_done", mode),      c, 32'(done),      32'(e_dn));
            chk($sformatf("m%0d_cfg_err", mode),   c, 32'(cfg_err),   32'(e_ce));
            chk($sformatf("m%0d_w_ready", mode),   c, 32'(w_ready),   32'(e_wl));
            chk($sformatf("m%0d_sa_w_load", mode), c, 32'(sa_w_load), 32'(e_wl));
            chk($sformatf("m%0d_w_row", mode),     c, 32'(w_row),     32'(e_row));
            chk($sformatf("m%0d_a_ready", mode),   c, 32'(a_ready),   32'(e_ar));
            chk($sformatf("m%0d_sa_en", mode),     c, 32'(sa_en),     32'(e_en));
            chk($sformatf("m%0d_a_zero", mode),    c, 32'(a_zero),    32'(e_az));
            chk($sformatf("m%0d_res_valid", mode), c, 32'(res_valid), 32'(e_rv));
            chk($sformatf("m%0d_res_last", mode),  c, 32'(res_last),  32'(e_rl));
            @(posedge ACLK);
            #1;
        end
        start  = 1'b0;
        abort  = 1'b0;
        ARESET = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; start = 1'b0; abort = 1'b0; cfg_m = 4'd0;
        w_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_outs", 0,
            32'({busy, done, cfg_err, w_ready, w_row, sa_w_load, a_ready, sa_en, a_zero, res_valid, res_last}),
            32'd0);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        run(0, 17);
        run(1, 20);
        run(2, 19);
        run(6, 4);
        run(4, 20);
        run(0, 17);
        run(5, 25);
        run(0, 17);
        run(3, 30);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sa_tile_scheduler.md
SA_TILE_SCHEDULER -- requirements
Module: sa_tile_scheduler

Interface
REQ-001 SHALL have parameter ARRAY_N, default 8: systolic array dimension (rows = columns).
REQ-002 SHALL have parameter DIM_W, default 16: width of the activation row-count field.
REQ-003 SHALL define derived constant LAT = 2*ARRAY_N-1: array pipeline depth in advancing cycles.
REQ-004 SHALL have ports, with clock and reset listed first:
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous and active-high.
- start  in  1  start a tile; sampled in IDLE only.
- abort  in  1  synchronous abort of the current tile.
- cfg_m  in  DIM_W  activation row count, latched at start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on tile completion.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- w_valid  in  1  weight-row valid from the fetch unit.
- w_ready  out  1  weight-row ready.
- w_row  out  clog2(ARRAY_N)  index of the weight row being loaded.
- sa_w_load  out  1  array weight-register load strobe.
- a_valid  in  1  activation-row valid.
- a_ready  out  1  activation-row ready.
- sa_en  out  1  array global advance enable.
- a_zero  out  1  inject a zero (bubble) row into the array.
- res_valid  out  1  result row valid at the array output.
- res_ready  in  1  downstream writer ready.
- res_last  out  1  marks the final result row of the tile.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD_W, STREAM, FLUSH, DONE.
REQ-006 SHALL handle start in IDLE:
- start=1 with cfg_m!=0: latch cfg_m, enter LOAD_W next cycle.
- start=1 with cfg_m==0: pulse cfg_err for one cycle, remain in IDLE.
- start in any other state: ignored.
REQ-007 LOAD_W SHALL behave as follows:
- w_ready=1.
- sa_w_load = w_valid & w_ready.
- w_row starts at 0 and increments on each transfer.
- The ARRAY_N-th transfer moves the FSM to STREAM; w_row returns to 0.
REQ-008 SHALL define adv = !res_valid | res_ready, and drive sa_en = adv & (state==STREAM | state==FLUSH).
REQ-009 STREAM SHALL behave as follows:
- a_ready = adv while fewer than cfg_m rows have been accepted.
- a_valid=0 while sa_en=1: a_zero=1 (bubble row); the accepted-row count is unchanged.
- Acceptance of the cfg_m-th row moves the FSM to FLUSH.
REQ-010 FLUSH SHALL drive a_ready=0 and a_zero=1 whenever sa_en=1.
REQ-011 SHALL keep a LAT-bit valid shift register that shifts only when sa_en=1:
- Bit shifted in is 1 for an accepted row, 0 for a bubble.
- res_valid = oldest bit.
REQ-012 A row accepted in cycle t with res_ready held at 1 SHALL produce res_valid in cycle t+LAT.
REQ-013 SHALL count accepted results (res_valid & res_ready):
- res_last = res_valid when the count equals cfg_m-1.
- Acceptance of the last result moves the FSM to DONE.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-015 While res_valid=1 and res_ready=0, SHALL hold sa_en=0, a_ready=0, and keep res_valid/res_last stable.
REQ-016 abort=1 in any non-IDLE state SHALL act as follows:
- Enter IDLE next cycle.
- Clear the shift register and all counters.
- Produce no done pulse.
- abort has priority over every other event in the same cycle.
REQ-017 SHALL keep counters DIM_W bits wide; cfg_m = 2^DIM_W-1 SHALL complete without wrap.

Reset
REQ-018 ARESET=1 SHALL, at the next rising edge:
- Force the FSM to IDLE.
- Clear the shift register and all counters.
- Drive every output to 0 (w_row=0), including when reset arrives mid-tile.
REQ-019 ARESET SHALL have priority over abort and start.

Verification
REQ-020 Nominal (ARRAY_N=4, LAT=7, cfg_m=3, start pulsed in cycle 0, all valids/readies at 1):
- sa_w_load in cycles 1-4, w_row 0,1,2,3.
- a_ready in cycles 5-7.
- res_valid in cycles 12-14, res_last in cycle 14.
- done in cycle 15; busy=0 from cycle 16.
REQ-021 Backpressure (same setup, res_ready=0 in cycles 12-14):
- res_valid held with sa_en=0.
- Results accepted in cycles 15-17.
- done in cycle 18.
REQ-022 Bubbles (a_valid=0 in cycles 5-6):
- a_zero=1 and sa_en=1 in cycles 5-6.
- Rows accepted in cycles 7-9.
- res_valid in cycles 14-16.
REQ-023 cfg_m=0 with start -> cfg_err=1 for one cycle, busy stays 0, no weight transfer.
REQ-024 abort in cycle 6 of the nominal case:
- IDLE in cycle 7, all outputs 0, no done.
- A subsequent start completes normally.
REQ-025 ARESET=1 in cycle 10 of the nominal case -> all outputs 0 in cycle 11, res_valid never asserted.
